// File: rtl/alu_sched_if.sv
// Bundle of requester, shared-ALU and response signals around alu_sched.
// slave is the scheduler's view; master is the surrounding system's view.
interface alu_sched_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [4:0]  req0_op;
  logic [63:0] req0_a;
  logic [63:0] req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [4:0]  req1_op;
  logic [63:0] req1_a;
  logic [63:0] req1_b;
  logic [4:0]  alu_op;
  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic        alu_pass;
  logic [3:0]  alu_state;
  logic [63:0] alu_res;
  logic        alu_error;
  logic        rsp_valid;
  logic        rsp_id;
  logic [63:0] rsp_data;
  logic        rsp_error;
  logic        rsp_ready;
  logic        busy;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  alu_res, alu_error, rsp_ready,
    output req0_ready, req1_ready,
    output alu_op, alu_a, alu_b, alu_pass, alu_state,
    output rsp_valid, rsp_id, rsp_data, rsp_error, busy
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output alu_res, alu_error, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_op, alu_a, alu_b, alu_pass, alu_state,
    input  rsp_valid, rsp_id, rsp_data, rsp_error, busy
  );
endinterface

// File: rtl/alu_sched.sv
// Two-requester round-robin scheduler in front of a shared multi-cycle ALU.
// state | meaning
// IDLE  | waiting for a request; ready is offered to the granted requester
// EXEC  | ALU running the latched op; counter counts down to capture
// RESP  | response held on rsp_* until the consumer takes it
module alu_sched #(
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned DIV_LAT = 4
) (
  input logic       clk,
  input logic       rst_n,
  alu_sched_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  localparam logic [3:0] MUL_LD = 4'(MUL_LAT - 1);
  localparam logic [3:0] DIV_LD = 4'(DIV_LAT - 1);

  state_t      state;
  logic        last_grant;
  logic [3:0]  cnt;
  logic [4:0]  op_q;
  logic [63:0] a_q;
  logic [63:0] b_q;
  logic        id_q;
  logic        rsp_valid_q;
  logic [63:0] data_q;
  logic        err_q;
  logic        busy_q;
  logic [3:0]  alu_state_q;

  logic        grant1;
  logic        ready0;
  logic        ready1;
  logic        accept;
  logic [4:0]  acc_op;
  logic [63:0] acc_a;
  logic [63:0] acc_b;

  function automatic logic is_legal(input logic [4:0] op);
    return (op <= 5'h0D) || (op == 5'h17) || (op >= 5'h19 && op <= 5'h1C);
  endfunction

  function automatic logic [3:0] load_of(input logic [4:0] op);
    case (op)
      5'h04, 5'h1B: return MUL_LD;
      5'h05, 5'h1C: return DIV_LD;
      default:      return 4'd0;
    endcase
  endfunction

  // req1 wins only when alone or when req0 took the previous grant
  assign grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant);
  assign ready0 = (state == S_IDLE) && bus.req0_valid && !grant1;
  assign ready1 = (state == S_IDLE) && grant1;
  assign accept = ready0 || ready1;
  assign acc_op = grant1 ? bus.req1_op : bus.req0_op;
  assign acc_a  = grant1 ? bus.req1_a  : bus.req0_a;
  assign acc_b  = grant1 ? bus.req1_b  : bus.req0_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      last_grant  <= 1'b1;
      cnt         <= 4'd0;
      op_q        <= 5'd0;
      a_q         <= 64'd0;
      b_q         <= 64'd0;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      data_q      <= 64'd0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      alu_state_q <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            last_grant <= grant1;
            id_q       <= grant1;
            op_q       <= acc_op;
            a_q        <= acc_a;
            b_q        <= acc_b;
            busy_q     <= 1'b1;
            if (is_legal(acc_op)) begin
              state       <= S_EXEC;
              cnt         <= load_of(acc_op);
              alu_state_q <= 4'b0010;
            end else begin
              state       <= S_RESP;
              rsp_valid_q <= 1'b1;
              data_q      <= 64'd0;
              err_q       <= 1'b1;
            end
          end
        end
        S_EXEC: begin
          if (cnt == 4'd0) begin
            state       <= S_RESP;
            rsp_valid_q <= 1'b1;
            data_q      <= bus.alu_res;
            err_q       <= bus.alu_error;
            alu_state_q <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            state       <= S_IDLE;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.alu_op     = op_q;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.alu_pass   = 1'b0;
  assign bus.alu_state  = alu_state_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = id_q;
  assign bus.rsp_data   = data_q;
  assign bus.rsp_error  = err_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_alu_sched.sv
// Bench for alu_sched: directed scenarios plus a cycle-timestamp reference model
// checked on every falling edge.
module tb_alu_sched;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  alu_sched_if bus();

  alu_sched #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the shared ALU: {error, result}
  function automatic logic [64:0] alu_fn(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
    case (op)
      5'h00:        return {1'b0, a + b};
      5'h01:        return {1'b0, a - b};
      5'h04, 5'h1B: return {1'b0, a * b};
      5'h05, 5'h1C: return (b == 64'd0) ? {1'b1, 64'd0} : {1'b0, a / b};
      default:      return {1'b0, a ^ b};
    endcase
  endfunction

  logic [64:0] alu_out;
  assign alu_out       = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);
  assign bus.alu_res   = alu_out[63:0];
  assign bus.alu_error = alu_out[64];

  function automatic bit legal_op(input logic [4:0] op);
    return (op <= 5'h0D) || (op == 5'h17) || (op >= 5'h19 && op <= 5'h1C);
  endfunction

  function automatic int lat_of(input logic [4:0] op);
    if (op == 5'h04 || op == 5'h1B) return MUL_LAT;
    if (op == 5'h05 || op == 5'h1C) return DIV_LAT;
    return 1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a transaction accepted before cycle m_acc executes in
  // cycles [m_acc, m_acc+m_lat) and then waits in response until taken.
  bit          m_busy = 0;
  bit          m_last = 1;
  bit          m_legal = 0;
  bit          m_id = 0;
  int          m_acc = 0;
  int          m_lat = 0;
  logic [4:0]  m_op = '0;
  logic [63:0] m_a = '0;
  logic [63:0] m_b = '0;
  logic [63:0] m_data = '0;
  bit          m_err = 0;

  always @(negedge clk) begin
    bit exec_now, resp_now, e_r0, e_r1;
    logic [64:0] r;
    if (!rst_n) begin
      m_busy = 0; m_last = 1; m_op = '0; m_a = '0; m_b = '0;
      chk("rst_busy", bus.busy, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_id", bus.rsp_id, 0);
      chk("rst_rsp_data", bus.rsp_data, 0);
      chk("rst_rsp_error", bus.rsp_error, 0);
      chk("rst_alu_state", bus.alu_state, 0);
      chk("rst_alu_op", bus.alu_op, 0);
      chk("rst_alu_a", bus.alu_a, 0);
      chk("rst_alu_b", bus.alu_b, 0);
    end else begin
      exec_now = m_busy && m_legal && (cyc < m_acc + m_lat);
      resp_now = m_busy && !exec_now;
      e_r0 = 0; e_r1 = 0;
      if (!m_busy) begin
        if (bus.req0_valid && bus.req1_valid) begin
          if (m_last) e_r0 = 1; else e_r1 = 1;
        end else begin
          e_r0 = bus.req0_valid;
          e_r1 = bus.req1_valid;
        end
      end
      chk("req0_ready", bus.req0_ready, e_r0);
      chk("req1_ready", bus.req1_ready, e_r1);
      chk("busy", bus.busy, m_busy);
      chk("rsp_valid", bus.rsp_valid, resp_now);
      chk("alu_state", bus.alu_state, exec_now ? 64'd2 : 64'd0);
      chk("alu_pass", bus.alu_pass, 0);
      chk("alu_op", bus.alu_op, m_op);
      chk("alu_a", bus.alu_a, m_a);
      chk("alu_b", bus.alu_b, m_b);
      if (resp_now) begin
        chk("rsp_id", bus.rsp_id, m_id);
        chk("rsp_data", bus.rsp_data, m_data);
        chk("rsp_error", bus.rsp_error, m_err);
      end
      if (e_r0 || e_r1) begin
        m_busy = 1;
        m_acc  = cyc + 1;
        m_id   = e_r1;
        m_last = e_r1;
        m_op   = e_r1 ? bus.req1_op : bus.req0_op;
        m_a    = e_r1 ? bus.req1_a  : bus.req0_a;
        m_b    = e_r1 ? bus.req1_b  : bus.req0_b;
        m_legal = legal_op(m_op);
        m_lat  = lat_of(m_op);
        if (m_legal) begin
          r = alu_fn(m_op, m_a, m_b);
          m_data = r[63:0];
          m_err  = r[64];
        end else begin
          m_data = '0;
          m_err  = 1;
        end
      end else if (resp_now && bus.rsp_ready) begin
        m_busy = 0;
      end
    end
  end

  task automatic send(input bit id, input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                      output int acc);
    bit rdy;
    @(posedge clk); #2;
    if (id) begin
      bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1;
    end else begin
      bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1;
    end
    acc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      rdy = id ? bus.req1_ready : bus.req0_ready;
      if (rdy) begin
        acc = cyc;
        break;
      end
    end
    @(posedge clk); #2;
    if (id) bus.req1_valid = 1'b0; else bus.req0_valid = 1'b0;
    if (acc < 0) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: got no ready expected ready for id %0d", id);
    end
  endtask

  task automatic wait_rsp(input int acc, output int lat, output int n_exec);
    lat = -1;
    n_exec = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.alu_state == 4'd2) n_exec++;
      if (bus.rsp_valid) begin
        lat = cyc - acc;
        break;
      end
    end
    if (lat < 0) begin
      n_tests++; n_fail++;
      $display("FAIL rsp_timeout: got no rsp_valid expected rsp_valid");
    end
  endtask

  task automatic run_op(input string name, input bit id, input logic [4:0] op, input logic [63:0] a,
                        input logic [63:0] b, input int exp_lat, input int exp_exec,
                        input logic [63:0] exp_data, input bit exp_err);
    int acc, lat, nx;
    send(id, op, a, b, acc);
    wait_rsp(acc, lat, nx);
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_exec_cycles"}, nx, exp_exec);
    chk({name, "_id"}, bus.rsp_id, id);
    chk({name, "_data"}, bus.rsp_data, exp_data);
    chk({name, "_error"}, bus.rsp_error, exp_err);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2; rst_n = 1'b0;
    @(posedge clk); #2; rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, lat, nx, n_rsp;
    int grants[$];
    logic [63:0] d0;
    logic id0, e0;
    bus.req0_valid = 0; bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 0; bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // single add, divide by zero, illegal op, assorted legal ops
    run_op("add", 0, 5'h00, 64'd5, 64'd7, 2, 1, 64'd12, 0);
    run_op("div0", 1, 5'h05, 64'd9, 64'd0, DIV_LAT + 1, DIV_LAT, 64'd0, 1);
    run_op("illegal", 0, 5'h12, 64'd3, 64'd4, 1, 0, 64'd0, 1);
    run_op("mul", 1, 5'h1B, 64'd6, 64'd7, MUL_LAT + 1, MUL_LAT, 64'd42, 0);
    run_op("xor17", 0, 5'h17, 64'hF0, 64'h0F, 2, 1, 64'hFF, 0);
    run_op("div", 0, 5'h1C, 64'd100, 64'd7, DIV_LAT + 1, DIV_LAT, 64'd14, 0);
    run_op("illegal1f", 1, 5'h1F, 64'd1, 64'd1, 1, 0, 64'd0, 1);
    run_op("sub", 1, 5'h01, 64'd3, 64'd5, 2, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0);

    // backpressure: three RESP cycles with rsp_ready low
    @(posedge clk); #2; bus.rsp_ready = 1'b0;
    send(0, 5'h01, 64'd20, 64'd8, acc);
    wait_rsp(acc, lat, nx);
    chk("bp_latency", lat, 2);
    d0 = bus.rsp_data; id0 = bus.rsp_id; e0 = bus.rsp_error;
    chk("bp_data", d0, 64'd12);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #2;
      bus.req1_op = 5'h00; bus.req1_a = 64'd1; bus.req1_b = 64'd1; bus.req1_valid = 1'b1;
      @(negedge clk);
      chk("bp_valid_held", bus.rsp_valid, 1);
      chk("bp_data_held", bus.rsp_data, d0);
      chk("bp_id_held", bus.rsp_id, id0);
      chk("bp_err_held", bus.rsp_error, e0);
      chk("bp_ready0_low", bus.req0_ready, 0);
      chk("bp_ready1_low", bus.req1_ready, 0);
    end
    @(posedge clk); #2; bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", bus.rsp_valid, 1);
    @(posedge clk); #2;
    @(negedge clk);
    chk("bp_idle_busy", bus.busy, 0);
    chk("bp_idle_ready1", bus.req1_ready, 1);
    acc = cyc;
    @(posedge clk); #2; bus.req1_valid = 1'b0;
    wait_rsp(acc, lat, nx);
    chk("bp_next_data", bus.rsp_data, 64'd2);
    chk("bp_next_id", bus.rsp_id, 1);

    // tie after reset: grants alternate starting with requester 0
    pulse_reset();
    @(posedge clk); #2;
    bus.req0_op = 5'h00; bus.req0_a = 64'd1;  bus.req0_b = 64'd2;
    bus.req1_op = 5'h00; bus.req1_a = 64'd10; bus.req1_b = 64'd20;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    for (int i = 0; i < 60 && grants.size() < 4; i++) begin
      @(negedge clk);
      if (bus.req0_ready) grants.push_back(0);
      if (bus.req1_ready) grants.push_back(1);
    end
    @(posedge clk); #2; bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    chk("tie_count", grants.size(), 4);
    while (grants.size() < 4) grants.push_back(9);
    chk("tie_grant0", grants[0], 0);
    chk("tie_grant1", grants[1], 1);
    chk("tie_grant2", grants[2], 0);
    chk("tie_grant3", grants[3], 1);
    repeat (4) @(posedge clk);

    // reset during the third EXEC cycle of a multiply
    send(0, 5'h04, 64'd3, 64'd5, acc);
    @(negedge clk);
    @(posedge clk); #2;
    @(negedge clk);
    chk("mid_exec_state", bus.alu_state, 2);
    @(posedge clk); #2; rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_alu_state", bus.alu_state, 0);
    chk("mid_rst_rsp_valid", bus.rsp_valid, 0);
    chk("mid_rst_alu_op", bus.alu_op, 0);
    chk("mid_rst_alu_a", bus.alu_a, 0);
    chk("mid_rst_alu_b", bus.alu_b, 0);
    @(posedge clk); #2; rst_n = 1'b1;
    n_rsp = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) n_rsp++;
    end
    chk("mid_rst_no_rsp", n_rsp, 0);

    // normal operation resumes after reset
    run_op("post_rst_add", 1, 5'h00, 64'd40, 64'd2, 2, 1, 64'd42, 0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
